// File: rtl/rr_mux_register_if.sv
// rr_mux_register_if: stream bundle between N producers, the round-robin mux and one consumer.
interface rr_mux_register_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);
    logic [CHANNELS*WIDTH-1:0] inData;
    logic [CHANNELS-1:0]       inValid;
    logic [CHANNELS-1:0]       inLast;
    logic [CHANNELS-1:0]       inReady;
    logic [WIDTH-1:0]          out;
    logic                      outValid;
    logic                      outLast;
    logic [SELW-1:0]           outChannel;
    logic                      outReady;
    modport master (
        output inData, inValid, inLast, outReady,
        input  inReady, out, outValid, outLast, outChannel
    );
    modport slave (
        input  inData, inValid, inLast, outReady,
        output inReady, out, outValid, outLast, outChannel
    );
endinterface

// File: rtl/rr_mux_register.sv
// rr_mux_register: registered round-robin N:1 stream mux with valid/ready handshake.
// Define RR_MUX_LOCK_EN to pin the grant to a channel until its inLast beat (packet lock).
module rr_mux_register #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input logic               clock,
    input logic               reset,
    rr_mux_register_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);
    logic [SELW-1:0]     ptr, sel, ptr_next;
    logic [CHANNELS-1:0] grant;
    logic                found, can_load, xfer;
    logic [WIDTH-1:0]    out_q;
    logic                valid_q, last_q;
    logic [SELW-1:0]     chan_q;
`ifdef RR_MUX_LOCK_EN
    logic                locked;
    logic [SELW-1:0]     lock_ch;
`endif
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            int t;
            t = int'(ptr) + k;
            if (t >= CHANNELS) t -= CHANNELS;
            if (!found && bus.inValid[t]) begin
                found = 1'b1;
                sel   = SELW'(t);
            end
        end
`ifdef RR_MUX_LOCK_EN
        // A locked packet owns the output; others wait even if the owner idles.
        if (locked) begin
            found = bus.inValid[lock_ch];
            sel   = lock_ch;
        end
`endif
        grant = found ? CHANNELS'(1) << sel : '0;
    end
    assign can_load    = (~valid_q | bus.outReady) & ~reset;
    assign xfer        = found & can_load;
    assign ptr_next    = (int'(sel) == CHANNELS - 1) ? '0 : sel + 1'b1;
    assign bus.inReady = can_load ? grant : '0;
    assign bus.out        = out_q;
    assign bus.outValid   = valid_q;
    assign bus.outLast    = last_q;
    assign bus.outChannel = chan_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            chan_q  <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            out_q   <= bus.inData[sel*WIDTH +: WIDTH];
            valid_q <= 1'b1;
            last_q  <= bus.inLast[sel];
            chan_q  <= sel;
`ifdef RR_MUX_LOCK_EN
            if (bus.inLast[sel]) ptr <= ptr_next;
`else
            ptr     <= ptr_next;
`endif
        end else if (bus.outReady) begin
            valid_q <= 1'b0;
        end
    end
`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            locked  <= ~bus.inLast[sel];
            lock_ch <= sel;
        end
    end
`endif
endmodule

// File: tb/tb_rr_mux_register.sv
// tb_rr_mux_register: directed checks of grant order, handshake, stall, reset and packet lock.
module tb_rr_mux_register;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    rr_mux_register_if #(.WIDTH(16), .CHANNELS(4)) bus ();
    rr_mux_register #(.WIDTH(16), .CHANNELS(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic set_data(input logic [15:0] d0, d1, d2, d3);
        bus.inData = {d3, d2, d1, d0};
    endtask
    initial begin
        int exp_seq[4];
        int ch0_beats;
        bus.inData   = '0;
        bus.inValid  = '0;
        bus.inLast   = '0;
        bus.outReady = 1'b0;
        #1;
        chk("rst_outValid", 32'(bus.outValid), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_outChannel", 32'(bus.outChannel), 0);
        chk("rst_outLast", 32'(bus.outLast), 0);
        bus.inValid  = 4'hF;
        bus.outReady = 1'b1;
        #1;
        chk("rst_inReady_zero", 32'(bus.inReady), 0);
        bus.inValid = '0;
        tick();
        reset = 1'b0;
        // single channel 2 beat
        set_data(16'h0, 16'h0, 16'hABCD, 16'h0);
        bus.inLast  = 4'b0100;
        bus.inValid = 4'b0100;
        #1;
        chk("ch2_inReady", 32'(bus.inReady), 32'b0100);
        tick();
        chk("ch2_out", 32'(bus.out), 32'hABCD);
        chk("ch2_outChannel", 32'(bus.outChannel), 2);
        chk("ch2_outValid", 32'(bus.outValid), 1);
        chk("ch2_outLast", 32'(bus.outLast), 1);
        bus.inValid = '0;
        #1;
        chk("idle_inReady", 32'(bus.inReady), 0);
        tick();
        chk("drain_outValid", 32'(bus.outValid), 0);
        chk("drain_out_kept", 32'(bus.out), 32'hABCD);
        // ch3 alone moves ptr to 0, then ch1 and ch3 compete
        set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus.inLast  = 4'hF;
        bus.inValid = 4'b1000;
        tick();
        chk("ch3_outChannel", 32'(bus.outChannel), 3);
        chk("ch3_out", 32'(bus.out), 32'h4444);
        bus.inValid = 4'b1010;
        #1;
        chk("pair_inReady_ch1", 32'(bus.inReady), 32'b0010);
        tick();
        chk("pair_first_ch1", 32'(bus.outChannel), 1);
        chk("pair_first_out", 32'(bus.out), 32'h2222);
        chk("pair_inReady_ch3", 32'(bus.inReady), 32'b1000);
        tick();
        chk("pair_second_ch3", 32'(bus.outChannel), 3);
        // all channels valid: strict rotation with no bubbles
        set_data(16'h1000, 16'h1001, 16'h1002, 16'h1003);
        bus.inValid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr_ch_%0d", k), 32'(bus.outChannel), k % 4);
            chk($sformatf("rr_out_%0d", k), 32'(bus.out), 32'h1000 + k % 4);
            chk($sformatf("rr_valid_%0d", k), 32'(bus.outValid), 1);
        end
        // consumer stall holds the beat
        bus.outReady = 1'b0;
        #1;
        chk("stall_inReady0", 32'(bus.inReady), 0);
        for (int k = 0; k < 3; k++) begin
            set_data(16'h2000, 16'h2001, 16'h2002, 16'h2003);
            tick();
            chk($sformatf("stall_out_%0d", k), 32'(bus.out), 32'h1003);
            chk($sformatf("stall_ch_%0d", k), 32'(bus.outChannel), 3);
            chk($sformatf("stall_valid_%0d", k), 32'(bus.outValid), 1);
            chk($sformatf("stall_inReady_%0d", k), 32'(bus.inReady), 0);
        end
        bus.outReady = 1'b1;
        #1;
        chk("unstall_inReady", 32'(bus.inReady), 32'b0001);
        tick();
        chk("unstall_ch", 32'(bus.outChannel), 0);
        chk("unstall_out", 32'(bus.out), 32'h2000);
        // asynchronous reset while a beat is held
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_outValid", 32'(bus.outValid), 0);
        chk("async_rst_out", 32'(bus.out), 0);
        chk("async_rst_inReady", 32'(bus.inReady), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_first_ch", 32'(bus.outChannel), 0);
        // packet of three beats on ch0 competing with ch1
        bus.inValid = '0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
`ifdef RR_MUX_LOCK_EN
        exp_seq = '{0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        ch0_beats = 0;
        bus.inValid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            bus.inLast = {2'b00, 1'b1, ch0_beats >= 2};
            tick();
            chk($sformatf("pkt_ch_%0d", k), 32'(bus.outChannel), exp_seq[k]);
            if (exp_seq[k] == 0) ch0_beats++;
        end
        bus.inValid = '0;
        tick();
        chk("final_drain", 32'(bus.outValid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_mux_register.md
# rr_mux_register

Registered N-channel round-robin multiplexer with valid/ready handshaking, generalising the single-bit 2:1 select into a streaming arbiter. It merges CHANNELS input streams of WIDTH bits into one output stream. Arbitration among requesting channels is fair, so no software select is needed. It sits between multiple producers (e.g. ALU result, memory read-back, I/O) and a single shared consumer port.

## Interface
- WIDTH, 16, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SELW, $clog2(CHANNELS), width of channel index
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- inData  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- inValid  input  CHANNELS  per-channel request
- inLast  input  CHANNELS  per-channel end-of-packet marker
- inReady  output  CHANNELS  per-channel accept; one-hot or zero
- out  output  WIDTH  registered selected data
- outValid  output  1  out holds a beat
- outLast  output  1  registered inLast of the held beat
- outChannel  output  SELW  index of the channel that supplied the held beat
- outReady  input  1  consumer accepts

## Operation
- One-entry output register: holds out, outLast, outChannel, and outValid.
- canLoad = ~outValid | outReady.
- Grant: a round-robin search starts at pointer `ptr` and selects the first i with inValid[i]. Order is ptr, ptr+1, … , CHANNELS-1, 0, … , with wrap-around modulo CHANNELS.
- inReady[i] = canLoad & grant[i]. The path from inValid/outReady to inReady is combinational; no other input-to-output paths.
- Input transfer: on inValid[i] & inReady[i], the register loads inData[i], inLast[i], and i, and sets outValid=1.
- After a transfer from channel i, ptr becomes (i+1) mod CHANNELS.
- Output transfer: on outValid & outReady with no new load, outValid clears. Data is not cleared.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one. outValid stays 1, so full throughput is one beat per cycle.
- No requests: grant is zero, inReady is all zero, and ptr is unchanged.
- Held beat while outReady=0: out, outLast, outChannel, and outValid stay stable. inReady is all zero.
- Input data is sampled only on a transfer; changes on non-granted channels have no effect.

## Timing
- Latency: 1 cycle from input transfer to outValid=1.
- Throughput: 1 beat/cycle while outReady=1.
- Reset, asynchronous: outValid=0, out=0, outLast=0, outChannel=0, ptr=0, lock state cleared.
- Combinationally during reset: inReady=0.
- Reset mid-transfer: the held beat is discarded, and the first grant after release starts at channel 0.
- Fairness: with all channels continuously valid and outReady=1, each channel is granted exactly once every CHANNELS cycles.

## Configuration
- RR_MUX_LOCK_EN defined: packet lock.
  - After a granted beat with inLast=0, the grant is pinned to that channel, ignoring others, until a beat with inLast=1 from it is transferred.
  - ptr advances only on that last beat.
  - If the locked channel deasserts inValid, inReady is zero for all channels and the lock holds.
- RR_MUX_LOCK_EN undefined: arbitration is per beat.
  - inLast only feeds outLast; no lock state is built.

## Test plan
- Reset, then ch2 only valid with inData=16'hABCD, inLast=1, outReady=1 -> inReady=4'b0100. Next cycle out=16'hABCD, outChannel=2, outValid=1, outLast=1.
- All 4 channels valid continuously, outReady=1 -> outChannel sequence is 0,1,2,3,0,… with no bubbles.
- outValid=1 with outReady=0 for 3 cycles, all inputs valid -> out stable and inReady=0 throughout. The cycle outReady=1, the next beat loads.
- ch1 and ch3 valid, last grant was ch3 (ptr=0) -> ch1 granted next; then ch3.
- Reset asserted while outValid=1 -> outValid=0 immediately, without waiting for a clock edge. After release with all channels valid, the first outChannel is 0.
- RR_MUX_LOCK_EN: ch0 sends 3 beats with inLast=0,0,1 while ch1 is valid -> outChannel=0,0,0 then 1. Without the macro -> outChannel=0,1,0,1.
